// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a VGA connector. It produces the pixel position
//   bus (hCount/vCount) with aligned hSync/vSync/bright qualifiers, along with
//   pixel, line and frame strobes for downstream game-state logic. The
//   defaults give 640x480 @ 60 Hz from a 50 MHz clk with a divide-by-2 pixel
//   strobe.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   enable     in   when low, the divider, the counters and all outputs hold
//   hCount     out  current pixel column, 0..H_TOTAL-1
//   vCount     out  current line, 0..V_TOTAL-1
//   hSync      out  horizontal sync; its asserted level is SYNC_ACTIVE
//   vSync      out  vertical sync; its asserted level is SYNC_ACTIVE
//   bright     out  high while the position is inside the visible area
//   pix_tick   out  one-clk strobe in the cycle a new position first appears
//   line_tick  out  one-clk strobe when hCount becomes 0
//   frame_tick out  one-clk strobe when (hCount,vCount) becomes (0,0)
//
// H_TOTAL and V_TOTAL must each be <= 1024 so that they fit the 10-bit counts.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_tick,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // The boundaries are held at 11 bits because a sync end can sit exactly at 1024.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             advance;
  logic [10:0]      h_cur;
  logic [10:0]      v_cur;
  logic [10:0]      h_next;
  logic [10:0]      v_next;

  // The next position is computed ahead of time, so the qualifiers are
  // registered from the same values that load into the counters. This keeps
  // them aligned with the position and adds no latency.
  always_comb begin
    advance = enable && (div_reg == DIV_LAST);
    h_cur   = {1'b0, hCount};
    v_cur   = {1'b0, vCount};
    h_next  = h_cur + 11'd1;
    v_next  = v_cur;
    if (h_cur == H_LAST) begin
      h_next = 11'd0;
      v_next = (v_cur == V_LAST) ? 11'd0 : v_cur + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg    <= '0;
      // (H_TOTAL-1, V_TOTAL-1) is a blanking point outside sync, so the
      // reset outputs are consistent with the position they report.
      hCount     <= H_LAST[9:0];
      vCount     <= V_LAST[9:0];
      hSync      <= ~SYNC_ACTIVE;
      vSync      <= ~SYNC_ACTIVE;
      bright     <= 1'b0;
      pix_tick   <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pix_tick   <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      if (enable) begin
        div_reg <= advance ? '0 : div_reg + 1'b1;
      end
      if (advance) begin
        hCount     <= h_next[9:0];
        vCount     <= v_next[9:0];
        bright     <= (h_next < H_VIS) && (v_next < V_VIS);
        hSync      <= ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vSync      <= ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        pix_tick   <= 1'b1;
        line_tick  <= (h_next == 11'd0);
        frame_tick <= (h_next == 11'd0) && (v_next == 11'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. It drives two instances from the same stimulus:
// dut_a uses the default 640x480 timing with CLK_DIV=2, and dut_b uses a tiny
// raster with CLK_DIV=1 and active-high syncs, so frame wraps and vSync
// are reached within a short run.
//
// The reference model tracks only how many enabled clk edges have occurred
// since reset. From that count it derives the pixel index arithmetically.
module tb_vga_timing_gen;

  // dut_a: default timing
  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_DIV = 2;
  localparam bit A_ACT = 1'b0;
  // dut_b: small raster, 17 x 12 pixels
  localparam int B_HV = 10, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6,  B_VF = 1, B_VS = 2, B_VB = 3;
  localparam int B_DIV = 1;
  localparam bit B_ACT = 1'b1;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       pt;
    logic       lt;
    logic       ft;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  logic [9:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_vs, a_br, a_pt, a_lt, a_ft;
  logic b_hs, b_vs, b_br, b_pt, b_lt, b_ft;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
    .pix_tick(a_pt), .line_tick(a_lt), .frame_tick(a_ft)
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .CLK_DIV(B_DIV), .SYNC_ACTIVE(B_ACT)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
    .pix_tick(b_pt), .line_tick(b_lt), .frame_tick(b_ft)
  );

  obs_t q_a[$];
  obs_t q_b[$];
  int compared = 0;
  int mismatched = 0;

  // Enabled edges since reset, plus whether the latest edge produced a new pixel.
  int  na = 0, nb = 0;
  bit  sa = 0, sb = 0;

  // After n enabled edges, n/div pixels have been produced. Pixel 1 is (0,0),
  // and before the first pixel the generator sits at (H_TOTAL-1, V_TOTAL-1).
  function automatic obs_t model(input int n, input bit strobe,
                                 input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input int dv, input bit act);
    obs_t o;
    int ht, vt, k, p, h, v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    k  = n / dv;
    if (k == 0) begin
      h = ht - 1;
      v = vt - 1;
    end else begin
      p = (k - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
    end
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.br = (h < hv) && (v < vv);
    o.hs = (h >= hv + hf && h < hv + hf + hsw) ? act : ~act;
    o.vs = (v >= vv + vf && v < vv + vf + vsw) ? act : ~act;
    o.pt = strobe;
    o.lt = strobe && (h == 0);
    o.ft = strobe && (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t exp_a();
    return model(na, sa, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_DIV, A_ACT);
  endfunction

  function automatic obs_t exp_b();
    return model(nb, sb, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_DIV, B_ACT);
  endfunction

  // One clk cycle of stimulus. The model accounts for the edge that just
  // occurred. An optional reset is asserted 2 time units after the edge, well
  // before the next edge. The expectation is then queued, and finally enable
  // is set for the next edge.
  task automatic step(input bit en_next, input bit rst_assert, input bit rst_release);
    @(posedge clk);
    if (reset) begin
      na = 0; nb = 0; sa = 0; sb = 0;
    end else if (enable) begin
      na++; nb++;
      sa = (na % A_DIV) == 0;
      sb = (nb % B_DIV) == 0;
    end else begin
      sa = 0; sb = 0;
    end
    #2;
    if (rst_assert) begin
      reset = 1'b1;
      na = 0; nb = 0; sa = 0; sb = 0;
    end
    if (rst_release) reset = 1'b0;
    q_a.push_back(exp_a());
    q_b.push_back(exp_b());
    enable = en_next;
  endtask

  function automatic void check(input string name, input obs_t got, input obs_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b br=%b pt=%b lt=%b ft=%b, expected h=%0d v=%0d hs=%b vs=%b br=%b pt=%b lt=%b ft=%b",
               name, $time, got.h, got.v, got.hs, got.vs, got.br, got.pt, got.lt, got.ft,
               exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.pt, exp.lt, exp.ft);
    end
  endfunction

  // The monitor samples on the falling edge, away from the active edge.
  initial begin
    obs_t got;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        got = '{a_h, a_v, a_hs, a_vs, a_br, a_pt, a_lt, a_ft};
        check("dut_a", got, q_a.pop_front());
      end
      if (q_b.size() > 0) begin
        got = '{b_h, b_v, b_hs, b_vs, b_br, b_pt, b_lt, b_ft};
        check("dut_b", got, q_b.pop_front());
      end
    end
  end

  initial begin
    int guard;
    // Reset held, then released; run past the first line wrap of dut_a.
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (1700) step(1'b1, 1'b0, 1'b0);
    $display("phase: reset release and line 0 sweep issued");

    // Advance until dut_a sits at hCount=300 with div=1, then freeze for 37 edges.
    guard = 0;
    while (!(exp_a().h == 10'd300 && (na % A_DIV) == 1) && guard < 2000) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    enable = 1'b0;
    repeat (36) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    $display("phase: 37-clk enable freeze at hCount=300 issued");

    // Random enable pattern.
    repeat (3000) step($urandom_range(0, 9) != 0, 1'b0, 1'b0);
    $display("phase: random enable issued");

    // Asynchronous reset mid-cycle. It is checked at the next falling edge,
    // before any rising edge has occurred.
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (500) step(1'b1, 1'b0, 1'b0);
    $display("phase: asynchronous reset and restart issued");

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d entries left in queues, expected 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator that drives the VGA connector and feeds the pixel generator stage. It produces hSync, vSync, bright and the hCount/vCount position bus that the pixel generator consumes. Default timing is 640x480 @ 60 Hz from a 50 MHz clk, using a divide-by-2 pixel strobe. It also emits per-line and per-frame strobes for game-state update logic such as paddle and ball movement.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=1)
SYNC_ACTIVE, 0, logic level of asserted hSync/vSync

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  when low, freezes divider, counters and all outputs
hCount  out  10  current pixel column, 0..H_TOTAL-1
vCount  out  10  current line, 0..V_TOTAL-1
hSync  out  1  horizontal sync, asserted level = SYNC_ACTIVE
vSync  out  1  vertical sync, asserted level = SYNC_ACTIVE
bright  out  1  high iff hCount<H_VISIBLE and vCount<V_VISIBLE
pix_tick  out  1  one-clk strobe; high in the cycle new hCount/vCount values first appear
line_tick  out  1  one-clk strobe when hCount becomes 0
frame_tick  out  1  one-clk strobe when (hCount,vCount) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be <=1024.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values (asynchronous, while reset=1):
  - div counter = 0
  - hCount = H_TOTAL-1 (799), vCount = V_TOTAL-1 (524)
  - bright = 0
  - hSync = vSync = ~SYNC_ACTIVE
  - pix_tick = line_tick = frame_tick = 0
  - The reset position (799,524) is a legal blanking, non-sync point, so outputs are self-consistent.
- Divider: counts 0..CLK_DIV-1 while enable=1. The advance condition is div==CLK_DIV-1 and enable=1. With CLK_DIV=1, every enabled clk advances.
- On each advance edge:
  - hCount increments. At H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps from V_TOTAL-1 to 0.
  - bright, hSync, vSync are updated on the same edge from the new counts, so they are always aligned with hCount/vCount. There is zero latency between position and qualifiers.
- hSync is asserted iff H_VISIBLE+H_FRONT <= hCount < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vSync is asserted iff V_VISIBLE+V_FRONT <= vCount < V_VISIBLE+V_FRONT+V_SYNC (490..491). vSync changes only on advance edges where hCount becomes 0.
- Strobes, registered on the advance edge and cleared on the next clk:
  - pix_tick = 1 on every advance.
  - line_tick = 1 when the new hCount = 0.
  - frame_tick = 1 when the new (hCount,vCount) = (0,0).
  - All are 0 on non-advance cycles.
- First advance after reset release occurs on the CLK_DIV-th enabled clk edge. It yields (0,0), bright=1, and pix_tick = line_tick = frame_tick = 1.
- enable=0: div, counts, bright and syncs hold their values; all strobes are 0 from the next edge onward. On re-enable, the divider resumes from its held value, with no skipped or doubled pixel.
- Reset mid-frame: immediate asynchronous return to the reset values. The first post-reset advance is again (0,0) with frame_tick.
- Pixel period = CLK_DIV clks. Line = H_TOTAL*CLK_DIV clks (1600). Frame = 840000 clks.

Test Plan:
- Reset release, CLK_DIV=2, enable=1 -> hCount=799/vCount=524/bright=0/syncs=1 during reset; on the 2nd clk edge after release, (0,0), bright=1, pix/line/frame_tick=1 for exactly 1 clk.
- Horizontal sweep on line 0 -> bright falls when hCount goes 639->640; hSync=0 for hCount 656..751 (96 pixels, 192 clks); hCount wraps 799->0 with vCount 0->1 and line_tick=1.
- Full frame -> vSync=0 only for vCount 490..491 (1600 clks each, edges aligned to hCount=0); bright=0 for all vCount>=480; next frame_tick exactly 840000 clks after the previous one.
- Deassert enable for 37 clks at hCount=300, div=1 -> counts, bright and syncs frozen, strobes 0; after re-enable, the next advance gives hCount=301 on the first enabled edge.
- Assert reset asynchronously between clk edges at (412,250) -> outputs go to reset values without waiting for an edge; after release, the frame restarts at (0,0) with frame_tick.
- CLK_DIV=1 build -> pix_tick high every clk; frame period 420000 clks; hSync width 96 clks.
